// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 execute-stage condition logic.
//   - ALU function codes driven by the decode stage.
//   - jXX/cmovXX condition codes (ifun field).
//   - Condition-code layout {ZF, SF, OF} and its reset value.
package y86_pkg;

  // ALU function codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Branch / conditional-move conditions (ifun). Codes 7..15 never fire.
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // Flag bit positions inside the 3-bit condition-code word
  localparam int ZF_BIT = 2;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 0;

  // Reset value: ZF=1, SF=0, OF=0 (looks like the result of "x - x")
  localparam logic [2:0] CC_RESET = 3'b100;

  // Overflow only has meaning for the arithmetic operations.
  function automatic logic alu_is_arith(input logic [1:0] fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational jXX/cmovXX condition evaluator.
// Ports:
//   cc_i   [2:0] condition codes {ZF, SF, OF}
//   ifun_i [3:0] condition selector
//   cnd_o        1 when the selected condition holds
// Shared with the branch-verify logic, so it holds no state.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o
);

  logic zf;
  logic lt;

  assign zf = cc_i[ZF_BIT];
  // Signed less-than: sign of the result corrected by overflow
  assign lt = cc_i[SF_BIT] ^ cc_i[OF_BIT];

  always_comb begin
    cnd_o = 1'b0;
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = lt | zf;
      C_L:     cnd_o = lt;
      C_E:     cnd_o = zf;
      C_NE:    cnd_o = ~zf;
      C_GE:    cnd_o = ~lt;
      C_G:     cnd_o = ~lt & ~zf;
      default: cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// cc_unit: condition-code register and condition evaluator, execute stage.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   alu_fun [1:0]        ALU function of the E-stage instruction
//   alu_result [W-1:0]   ALU output
//   alu_ovf              ALU signed overflow
//   set_cc               E-stage instruction is OPq
//   suppress             exception in M/W; blocks the flag update
//   ifun [3:0]           jXX/cmovXX condition of the E-stage instruction
//   m_stall, m_bubble    control for the E->M condition register
//   cc [2:0]             registered flags {ZF, SF, OF}
//   e_cnd                condition evaluated against registered cc
//   m_cnd                e_cnd registered for the memory stage
module cc_unit
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   alu_fun,
  input  logic [W-1:0] alu_result,
  input  logic         alu_ovf,
  input  logic         set_cc,
  input  logic         suppress,
  input  logic [3:0]   ifun,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic [2:0]   cc,
  output logic         e_cnd,
  output logic         m_cnd
);

  logic [2:0] new_flags;
  logic [2:0] cc_d,    cc_q;
  logic       m_cnd_d, m_cnd_q;

  // Flags of the current ALU result. AND/XOR clear OF whatever the ALU says.
  always_comb begin
    new_flags         = '0;
    new_flags[ZF_BIT] = (alu_result == '0);
    new_flags[SF_BIT] = alu_result[W-1];
    new_flags[OF_BIT] = alu_ovf & alu_is_arith(alu_fun);
  end

  // A faulting instruction further down the pipe must not see younger flags.
  always_comb begin
    cc_d = cc_q;
    if (set_cc && !suppress) begin
      cc_d = new_flags;
    end
  end

  // Condition is evaluated against the registered flags only, so an OPq in
  // the same cycle does not affect the jXX/cmovXX alongside it.
  cond_eval u_cond_eval (
    .cc_i   (cc_q),
    .ifun_i (ifun),
    .cnd_o  (e_cnd)
  );

  // Bubble outranks stall.
  always_comb begin
    m_cnd_d = e_cnd;
    if (m_bubble) begin
      m_cnd_d = 1'b0;
    end else if (m_stall) begin
      m_cnd_d = m_cnd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q    <= CC_RESET;
      m_cnd_q <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      m_cnd_q <= m_cnd_d;
    end
  end

  assign cc    = cc_q;
  assign m_cnd = m_cnd_q;

endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: self-checking bench for cc_unit with a behavioural flag model.
module tb_cc_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_fun;
  logic [63:0] alu_result;
  logic        alu_ovf;
  logic        set_cc;
  logic        suppress;
  logic [3:0]  ifun;
  logic        m_stall;
  logic        m_bubble;
  logic [2:0]  cc;
  logic        e_cnd;
  logic        m_cnd;

  always #5 clk = ~clk;

  cc_unit #(.W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_fun    (alu_fun),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .set_cc     (set_cc),
    .suppress   (suppress),
    .ifun       (ifun),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc         (cc),
    .e_cnd      (e_cnd),
    .m_cnd      (m_cnd)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  // Reference state kept as separate named flags
  bit ref_zf, ref_sf, ref_of;
  bit ref_m_cnd;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Condition rules written from signed-compare semantics
  function automatic bit ref_cond(input bit zf, input bit sf, input bit of_f, input int code);
    bit less;
    less = (sf != of_f);
    if (code == 0) return 1;
    if (code == 1) return less || zf;
    if (code == 2) return less;
    if (code == 3) return zf;
    if (code == 4) return !zf;
    if (code == 5) return !less;
    if (code == 6) return !less && !zf;
    return 0;
  endfunction

  function automatic logic [2:0] ref_cc();
    return {ref_zf, ref_sf, ref_of};
  endfunction

  task automatic ref_reset();
    ref_zf = 1; ref_sf = 0; ref_of = 0;
    ref_m_cnd = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; drives one cycle, checks e_cnd before
  // the rising edge and cc/m_cnd just after it, ends on the next falling edge.
  task automatic drive_cycle(input logic [1:0] fun, input logic [63:0] res, input bit ovf,
                             input bit setc, input bit sup, input logic [3:0] fn,
                             input bit stall, input bit bubble);
    bit nz, ns, no, cnd_now;
    alu_fun = fun; alu_result = res; alu_ovf = ovf;
    set_cc = setc; suppress = sup; ifun = fn;
    m_stall = stall; m_bubble = bubble;
    #1;
    cnd_now = ref_cond(ref_zf, ref_sf, ref_of, int'(fn));
    check("e_cnd", {63'd0, e_cnd}, {63'd0, cnd_now});
    nz = (res == 64'd0);
    ns = res[63];
    no = ovf && (fun == 2'b00 || fun == 2'b01);
    @(posedge clk);
    if (bubble)      ref_m_cnd = 0;
    else if (!stall) ref_m_cnd = cnd_now;
    if (setc && !sup) begin
      ref_zf = nz; ref_sf = ns; ref_of = no;
    end
    exp_q.push_back(ref_cc());
    #1;
    check("cc", {61'd0, cc}, {61'd0, exp_q.pop_front()});
    check("m_cnd", {63'd0, m_cnd}, {63'd0, ref_m_cnd});
    @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle with a pending flag update that must be lost
  task automatic reset_pulse();
    alu_fun = 2'b01; alu_result = 64'h8000_0000_0000_0001; alu_ovf = 1;
    set_cc = 1; suppress = 0; m_stall = 0; m_bubble = 0;
    #2 rst = 1;
    ref_reset();
    #1;
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_m_cnd", {63'd0, m_cnd}, 64'd0);
    @(posedge clk); #1;
    check("rst_hold_cc", {61'd0, cc}, 64'd4);
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    alu_fun = 0; alu_result = 0; alu_ovf = 0; set_cc = 0; suppress = 0;
    ifun = 3; m_stall = 0; m_bubble = 0;
    ref_reset();
    #3;
    check("reset_cc", {61'd0, cc}, 64'd4);
    check("reset_m_cnd", {63'd0, m_cnd}, 64'd0);
    check("reset_e_cnd_e", {63'd0, e_cnd}, 64'd1);
    ifun = 4; #1;
    check("reset_e_cnd_ne", {63'd0, e_cnd}, 64'd0);
    @(negedge clk);
    rst = 0;

    // Subtract giving -5
    drive_cycle(2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 0, 1, 0, 4'd2, 0, 0);
    check("sub_cc", {61'd0, cc}, 64'd2);
    drive_cycle(2'b00, 64'd0, 0, 0, 0, 4'd2, 0, 0);  // e_cnd=1 (l)
    check("sub_m_cnd", {63'd0, m_cnd}, 64'd1);
    drive_cycle(2'b00, 64'd0, 0, 0, 0, 4'd6, 0, 0);  // e_cnd=0 (g)

    // Overflowing add, then XOR with ovf asserted
    drive_cycle(2'b00, 64'h8000_0000_0000_0000, 1, 1, 0, 4'd0, 0, 0);
    check("ovf_cc", {61'd0, cc}, 64'd3);
    drive_cycle(2'b11, 64'd0, 1, 1, 0, 4'd5, 0, 0);   // ge=1 from old flags
    check("xor_cc", {61'd0, cc}, 64'd4);

    // Suppression
    drive_cycle(2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 0, 1, 0, 4'd2, 0, 0);
    drive_cycle(2'b00, 64'd0, 0, 1, 1, 4'd2, 0, 0);
    check("sup_cc", {61'd0, cc}, 64'd2);
    drive_cycle(2'b00, 64'd0, 0, 1, 0, 4'd2, 0, 0);
    check("unsup_cc", {61'd0, cc}, 64'd4);

    // Stall / bubble on m_cnd
    drive_cycle(2'b00, 64'd0, 0, 0, 0, 4'd3, 0, 0);   // m_cnd <= 1
    drive_cycle(2'b00, 64'd0, 0, 0, 0, 4'd4, 1, 0);   // hold 1
    check("stall_m_cnd", {63'd0, m_cnd}, 64'd1);
    drive_cycle(2'b00, 64'd0, 0, 0, 0, 4'd0, 1, 1);   // bubble wins
    check("bubble_m_cnd", {63'd0, m_cnd}, 64'd0);

    // Illegal ifun across all eight flag combinations
    for (int c = 0; c < 8; c++) begin
      logic [63:0] r;
      r = (c[2]) ? 64'd0 : (c[1] ? 64'h8000_0000_0000_0010 : 64'd7);
      drive_cycle(2'b00, r, c[0], 1, 0, 4'd7, 0, 0);
      drive_cycle(2'b00, 64'd1, 0, 0, 0, 4'd15, 0, 0);
    end

    // Reset in the middle of operation
    reset_pulse();
    drive_cycle(2'b10, 64'h8000_0000_0000_0000, 1, 1, 0, 4'd3, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] r;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       r = 64'd0;
        1:       r = {1'b1, 31'd0, 32'($urandom)};
        default: r = {32'($urandom), 32'($urandom)};
      endcase
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        drive_cycle(2'($urandom_range(0, 3)), r, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      end
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
